interval_timer_ctrl: RTL
========================

# interval_timer_ctrl

Sequencer for the 8-bit up-counter. It turns the free-running counter into a programmable interval timer with one-shot and periodic modes.
- Owns the counter's enable and clear.
- Compares the count against a latched terminal value and emits per-interval ticks and an end-of-sequence done pulse.
- Sits between software-facing control (start/stop/config) and the counter datapath.

## Interface
Parameters:
- CNT_W, 8, counter and period width
- REP_W, 8, repetition-count width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin sequence; sampled in IDLE only
- stop  in  1  abort sequence; sampled in every non-IDLE state
- mode  in  1  0 = one-shot, 1 = periodic; latched on start
- period  in  CNT_W  terminal count; latched on start
- reps  in  REP_W  number of intervals in one-shot mode; latched on start; 0 is treated as 1
- count  out  CNT_W  current counter value (mirror of sub-module output)
- rep_left  out  REP_W  remaining intervals (one-shot)
- tick  out  1  one-cycle pulse at end of each interval
- done  out  1  one-cycle pulse at end of a one-shot sequence
- busy  out  1  high in CLEAR and RUN

## Operation
Reset (rst=0, asynchronous):
- State goes to IDLE; all outputs are 0; latched registers are cleared.
- The counter is held cleared, with its rst driven by ~rst OR clr_q.
- Reset mid-sequence aborts immediately, with no tick or done.

FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE: counter enable = 0. start=1 and stop=0 latches period_q, mode_q and rep_left (reps, or 1 if reps=0), then goes to CLEAR. start and stop together: stop wins, stay IDLE.
- CLEAR: clr_q=1 (registered, glitch-free) forces count to 0; enable = 0; goes to RUN next cycle.
- RUN: enable = 1 while count != period_q. When count == period_q:
  - enable = 0 and tick = 1.
  - Periodic mode: go to CLEAR.
  - One-shot mode: decrement rep_left; if rep_left was 1, go to DONE, else go to CLEAR.
- DONE: done=1 for one cycle, busy=0; goes to IDLE. start in DONE is ignored.

Other rules:
- stop in CLEAR, RUN or DONE: IDLE on next edge. stop suppresses tick and done in that cycle. count holds its value.
- start while busy: ignored; latched values are unchanged.
- Periodic mode: rep_left holds its latched value and is not decremented.
- Counter overflow output is unused. period_q ≤ 2^CNT_W−1, so count never wraps.

## Timing
Decodes:
- tick = (state==RUN) && (count==period_q) && !stop. This is a registered-state decode with no input-to-output path except stop.
- done = (state==DONE) && !stop.

Cycle timing, with start sampled at edge 0:
- cycle 1 is CLEAR.
- cycles 2..period_q+2 are RUN, with count = 0..period_q.
- tick occurs in cycle period_q+2.
- Interval spacing is period_q+2 cycles (1 clear cycle plus period_q+1 counting cycles).
- One-shot done occurs one cycle after the final tick.
- Total one-shot length is reps·(period_q+2)+1 cycles after start.

Edge cases:
- period=0: tick every 2 cycles.
- period=255: tick in cycle 257.

## Structure
Shared header interval_timer_defs:
- state encodings (2-bit localparams)
- MODE_ONESHOT / MODE_PERIODIC
- CNT_W default

The block contains one sub-module instance, counter (8-bit: clk, en, rst active-high, count, ovf), with ovf left open. All other logic is local: FSM, latches, compare.

## Test plan
- Reset: rst=0 during RUN with count=2 → busy, tick, done and count are 0 in the same cycle; after release, state is IDLE.
- One-shot, period=3, reps=2, start at cycle 0 → tick in cycles 5 and 10; rep_left 2→1→0; done in cycle 11; busy low from cycle 11.
- Periodic, period=0 → tick in cycles 2,4,6,…; stop in cycle 7 → IDLE at cycle 8, with no tick after cycle 6.
- One-shot, reps=0, period=1 → single tick in cycle 3; done in cycle 4.
- Protocol: start with period=5 during RUN of period=2 → intervals stay 4 cycles. start and stop together in IDLE → busy stays 0.
- One-shot, period=255, reps=1 → count reaches 255 without wrap; tick in cycle 257; done in cycle 258.

Source files
------------

// File: rtl/interval_timer_defs.sv
// Shared definitions for the interval timer: state encodings, mode values
// and the default counter width.
package interval_timer_defs;

    localparam int CNT_W_DEF = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        CLEAR = ST_CLEAR,
        RUN   = ST_RUN,
        DONE  = ST_DONE
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/interval_timer_ctrl_counter.sv
// Free-running up-counter with enable and asynchronous active-high clear.
// ovf flags the increment that would wrap from all-ones back to zero.
module counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         en,
    input  logic         rst,
    output logic [W-1:0] count,
    output logic         ovf
);

    // Count up while enabled; rst clears immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign ovf = en && (&count);

endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer sequencer: drives the up-counter's enable/clear, compares
// the count against a latched period and produces tick/done pulses for
// one-shot and periodic operation.
module interval_timer_ctrl
    import interval_timer_defs::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int REP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [CNT_W-1:0] period,
    input  logic [REP_W-1:0] reps,
    output logic [CNT_W-1:0] count,
    output logic [REP_W-1:0] rep_left,
    output logic             tick,
    output logic             done,
    output logic             busy
);

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   period_q;
    logic               mode_q;
    logic [REP_W-1:0]   rep_left_q;
    logic               clr_q;
    logic               cnt_en;
    logic               cnt_rst;
    logic               load;
    logic               dec;
    logic               at_term;

    assign at_term = (count == period_q);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state, counter enable and pulse decodes.
    always_comb begin
        state_next = state_reg;
        cnt_en     = 1'b0;
        tick       = 1'b0;
        done       = 1'b0;
        busy       = 1'b0;
        load       = 1'b0;
        dec        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && !stop) begin
                    load       = 1'b1;
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                busy       = 1'b1;
                state_next = stop ? IDLE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (stop) begin
                    state_next = IDLE;
                end else if (at_term) begin
                    tick = 1'b1;
                    if (mode_q == MODE_PERIODIC) begin
                        state_next = CLEAR;
                    end else begin
                        dec        = 1'b1;
                        state_next = (rep_left_q == {{(REP_W-1){1'b0}}, 1'b1}) ? DONE : CLEAR;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                done       = !stop;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Configuration latched on an accepted start; rep_left counts down in one-shot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_q   <= '0;
            mode_q     <= MODE_ONESHOT;
            rep_left_q <= '0;
        end else if (load) begin
            period_q   <= period;
            mode_q     <= mode;
            rep_left_q <= (reps == '0) ? {{(REP_W-1){1'b0}}, 1'b1} : reps;
        end else if (dec) begin
            rep_left_q <= rep_left_q - {{(REP_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter clear is registered from the next state so it is glitch-free
    // and is high for exactly the CLEAR cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_q <= 1'b0;
        end else begin
            clr_q <= (state_next == CLEAR);
        end
    end

    assign cnt_rst  = ~rst | clr_q;
    assign rep_left = rep_left_q;

    // Overflow is never used: count stops at period_q, which cannot exceed all-ones.
    counter #(
        .W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .en    (cnt_en),
        .rst   (cnt_rst),
        .count (count),
        .ovf   ()
    );

endmodule
